// File: rtl/weight_stream_loader.sv
// Write-side front end for one layer's neuron weight memories: parses header+weight
// packets from a valid/ready stream and drives the selected memory's write port.
module weight_stream_loader #(
    parameter int numNeuron    = 4,
    parameter int numWeight    = 3,
    parameter int layerNo      = 1,
    parameter int addressWidth = 10,
    parameter int dataWidth    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [dataWidth-1:0]    s_data,
    input  logic                    s_last,
    output logic [numNeuron-1:0]    wen,
    output logic [addressWidth-1:0] wadd,
    output logic [dataWidth-1:0]    win,
    output logic                    done,
    output logic [numNeuron-1:0]    loaded,
    output logic                    err
);

    typedef enum logic [1:0] {HDR, LOAD, SKIP} state_t;

    // One extra counter bit so a full 2^addressWidth packet never wraps.
    localparam logic [addressWidth:0] LAST_CNT = (addressWidth+1)'(numWeight - 1);

    state_t                state_reg;
    logic [7:0]            neuron_reg;
    logic [addressWidth:0] cnt_reg;
    logic [numNeuron-1:0]  hit;
    logic [7:0]            hdr_layer;
    logic [7:0]            hdr_neuron;
    logic                  hdr_in_range;
    logic                  cnt_at_last;

    genvar gi;
    generate
        for (gi = 0; gi < numNeuron; gi++) begin : g_hit
            assign hit[gi] = (neuron_reg == 8'(gi));
        end
    endgenerate

    assign hdr_layer    = s_data[15:8];
    assign hdr_neuron   = s_data[7:0];
    assign hdr_in_range = ({1'b0, hdr_neuron} < 9'(numNeuron));
    assign cnt_at_last  = (cnt_reg == LAST_CNT);
    assign s_ready      = rst_n & ~clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= HDR;
            neuron_reg <= '0;
            cnt_reg    <= '0;
            wen        <= '0;
            wadd       <= '0;
            win        <= '0;
            done       <= 1'b0;
            loaded     <= '0;
            err        <= 1'b0;
        end else begin
            wen  <= '0;
            done <= 1'b0;
            if (clr) begin
                state_reg <= HDR;
                loaded    <= '0;
                err       <= 1'b0;
            end else if (s_valid) begin
                case (state_reg)
                    HDR: begin
                        neuron_reg <= hdr_neuron;
                        cnt_reg    <= '0;
                        if (s_last) begin
                            err <= 1'b1;
                        end else if (hdr_layer == 8'(layerNo)) begin
                            if (hdr_in_range) begin
                                state_reg <= LOAD;
                            end else begin
                                state_reg <= SKIP;
                                err       <= 1'b1;
                            end
                        end else begin
                            state_reg <= SKIP;
                        end
                    end
                    LOAD: begin
                        wen     <= hit;
                        wadd    <= cnt_reg[addressWidth-1:0];
                        win     <= s_data;
                        cnt_reg <= cnt_reg + 1'b1;
                        if (cnt_at_last) begin
                            loaded    <= loaded | hit;
                            done      <= 1'b1;
                            state_reg <= HDR;
                            if (!s_last) err <= 1'b1;
                        end else if (s_last) begin
                            err       <= 1'b1;
                            state_reg <= HDR;
                        end
                    end
                    SKIP: begin
                        cnt_reg <= cnt_reg + 1'b1;
                        if (cnt_at_last) begin
                            state_reg <= HDR;
                            if (!s_last) err <= 1'b1;
                        end else if (s_last) begin
                            err       <= 1'b1;
                            state_reg <= HDR;
                        end
                    end
                    default: state_reg <= HDR;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_weight_stream_loader.sv
// Directed bench for weight_stream_loader: small layer (3 weights) plus a
// 1024-weight instance; memory writes are checked against a queue of expected writes.
module tb_weight_stream_loader;

    logic        clk = 1'b0;
    logic        rst_n, clr;
    logic        s_valid, s_last, s_ready;
    logic [15:0] s_data;
    logic [3:0]  wen, loaded;
    logic [9:0]  wadd;
    logic [15:0] win;
    logic        done, err;

    logic        b_valid, b_last, b_ready;
    logic [15:0] b_data;
    logic [3:0]  b_wen, b_loaded;
    logic [9:0]  b_wadd;
    logic [15:0] b_win;
    logic        b_done, b_err;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [3:0]  w;
        logic [9:0]  a;
        logic [15:0] d;
    } wr_t;
    wr_t exp_q[$];
    int  done_cnt = 0;
    int  b_wr_cnt = 0;
    int  b_done_cnt = 0;

    always #5 clk = ~clk;

    weight_stream_loader #(.numNeuron(4), .numWeight(3), .layerNo(1),
                           .addressWidth(10), .dataWidth(16)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .wen(wen), .wadd(wadd), .win(win),
        .done(done), .loaded(loaded), .err(err));

    weight_stream_loader #(.numNeuron(4), .numWeight(1024), .layerNo(1),
                           .addressWidth(10), .dataWidth(16)) dut_big (
        .clk(clk), .rst_n(rst_n), .clr(clr), .s_valid(b_valid), .s_ready(b_ready),
        .s_data(b_data), .s_last(b_last), .wen(b_wen), .wadd(b_wadd), .win(b_win),
        .done(b_done), .loaded(b_loaded), .err(b_err));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one beat; returns 1 time unit after the edge that accepts it.
    task automatic send(input logic [15:0] d, input logic l);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        @(posedge clk);
        #1;
    endtask

    task automatic send_w(input logic [3:0] w, input logic [9:0] a, input logic [15:0] d,
                          input logic l);
        exp_q.push_back('{w: w, a: a, d: d});
        send(d, l);
    endtask

    task automatic idle();
        s_valid = 1'b0;
        s_last  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (wen !== 4'b0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {28'b0, wen}, 32'h0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                $display("write wen=%b wadd=%0d win=%h", wen, wadd, win);
                chk("wr_wen", {28'b0, wen}, {28'b0, e.w});
                chk("wr_wadd", {22'b0, wadd}, {22'b0, e.a});
                chk("wr_win", {16'b0, win}, {16'b0, e.d});
            end
        end
        if (b_done) b_done_cnt++;
        if (b_wen !== 4'b0) begin
            chk("big_wen", {28'b0, b_wen}, 32'h1);
            chk("big_wadd", {22'b0, b_wadd}, 32'(b_wr_cnt));
            chk("big_win", {16'b0, b_win}, 32'(16'(b_wr_cnt) ^ 16'h5a5a));
            b_wr_cnt++;
        end
    end

    initial begin
        rst_n = 1'b0; clr = 1'b0;
        s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        b_valid = 1'b0; b_data = '0; b_last = 1'b0;
        #2;
        chk("rst_s_ready", {31'b0, s_ready}, 32'h0);
        chk("rst_wen", {28'b0, wen}, 32'h0);
        chk("rst_wadd", {22'b0, wadd}, 32'h0);
        chk("rst_win", {16'b0, win}, 32'h0);
        chk("rst_done", {31'b0, done}, 32'h0);
        chk("rst_loaded", {28'b0, loaded}, 32'h0);
        chk("rst_err", {31'b0, err}, 32'h0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_rst", {31'b0, s_ready}, 32'h1);

        // Load neuron 2 back-to-back
        send(16'h0102, 1'b0);
        send_w(4'b0100, 10'd0, 16'h0011, 1'b0);
        send_w(4'b0100, 10'd1, 16'h0022, 1'b0);
        send_w(4'b0100, 10'd2, 16'h0033, 1'b1);
        chk("t1_done", {31'b0, done}, 32'h1);
        chk("t1_loaded", {28'b0, loaded}, 32'h4);
        chk("t1_err", {31'b0, err}, 32'h0);
        idle();
        chk("t1_done_drop", {31'b0, done}, 32'h0);
        chk("t1_done_cnt", 32'(done_cnt), 32'd1);

        // Other layer is skipped silently, then neuron 0 loads
        send(16'h0200, 1'b0);
        send(16'h000a, 1'b0);
        send(16'h000b, 1'b0);
        send(16'h000c, 1'b1);
        chk("t2_skip_loaded", {28'b0, loaded}, 32'h4);
        chk("t2_skip_err", {31'b0, err}, 32'h0);
        send(16'h0100, 1'b0);
        send_w(4'b0001, 10'd0, 16'h0101, 1'b0);
        send_w(4'b0001, 10'd1, 16'h0202, 1'b0);
        send_w(4'b0001, 10'd2, 16'h0303, 1'b1);
        chk("t2_loaded", {28'b0, loaded}, 32'h5);
        chk("t2_err", {31'b0, err}, 32'h0);

        // Out-of-range neuron, then clr
        send(16'h0107, 1'b0);
        chk("t3_err_hdr", {31'b0, err}, 32'h1);
        send(16'h0001, 1'b0);
        send(16'h0002, 1'b0);
        send(16'h0003, 1'b1);
        clr = 1'b1; s_valid = 1'b1; s_data = 16'h0102; s_last = 1'b0;
        #1;
        chk("t3_ready_in_clr", {31'b0, s_ready}, 32'h0);
        @(posedge clk); #1;
        clr = 1'b0; s_valid = 1'b0;
        chk("t3_clr_err", {31'b0, err}, 32'h0);
        chk("t3_clr_loaded", {28'b0, loaded}, 32'h0);
        chk("t3_clr_wen", {28'b0, wen}, 32'h0);

        // Short packet to neuron 1, next word is a header
        send(16'h0101, 1'b0);
        send_w(4'b0010, 10'd0, 16'h00aa, 1'b0);
        send_w(4'b0010, 10'd1, 16'h00bb, 1'b1);
        chk("t4_err", {31'b0, err}, 32'h1);
        chk("t4_loaded", {28'b0, loaded}, 32'h0);
        send(16'h0100, 1'b0);
        send_w(4'b0001, 10'd0, 16'h1111, 1'b0);
        send_w(4'b0001, 10'd1, 16'h2222, 1'b0);
        send_w(4'b0001, 10'd2, 16'h3333, 1'b1);
        chk("t4_loaded_n0", {28'b0, loaded}, 32'h1);

        // Overlong packet: last weight without s_last, following word is a header
        clr = 1'b1; idle(); clr = 1'b0;
        send(16'h0102, 1'b0);
        send_w(4'b0100, 10'd0, 16'h0c01, 1'b0);
        send_w(4'b0100, 10'd1, 16'h0c02, 1'b0);
        send_w(4'b0100, 10'd2, 16'h0c03, 1'b0);
        chk("t4b_err", {31'b0, err}, 32'h1);
        send(16'h0103, 1'b0);
        send_w(4'b1000, 10'd0, 16'h0d01, 1'b0);
        send_w(4'b1000, 10'd1, 16'h0d02, 1'b0);
        send_w(4'b1000, 10'd2, 16'h0d03, 1'b1);
        chk("t4b_loaded", {28'b0, loaded}, 32'hc);

        // Asynchronous reset mid-packet
        send(16'h0103, 1'b0);
        send_w(4'b1000, 10'd0, 16'h0077, 1'b0);
        #6 rst_n = 1'b0;
        #1;
        chk("t5_rst_wen", {28'b0, wen}, 32'h0);
        chk("t5_rst_wadd", {22'b0, wadd}, 32'h0);
        chk("t5_rst_win", {16'b0, win}, 32'h0);
        chk("t5_rst_loaded", {28'b0, loaded}, 32'h0);
        chk("t5_rst_err", {31'b0, err}, 32'h0);
        chk("t5_rst_ready", {31'b0, s_ready}, 32'h0);
        s_valid = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        send(16'h0103, 1'b0);
        send_w(4'b1000, 10'd0, 16'h0e01, 1'b0);
        send_w(4'b1000, 10'd1, 16'h0e02, 1'b0);
        send_w(4'b1000, 10'd2, 16'h0e03, 1'b1);
        chk("t5_loaded", {28'b0, loaded}, 32'h8);
        chk("t5_err", {31'b0, err}, 32'h0);
        idle();
        idle();
        chk("small_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("small_done_cnt", 32'(done_cnt), 32'd6);

        // 1024-weight packet with random valid gaps
        b_valid = 1'b1; b_data = 16'h0100; b_last = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 1024; i++) begin
            while ($urandom_range(0, 3) == 0) begin
                b_valid = 1'b0;
                @(posedge clk); #1;
            end
            b_valid = 1'b1;
            b_data  = 16'(i) ^ 16'h5a5a;
            b_last  = (i == 1023);
            @(posedge clk); #1;
        end
        b_valid = 1'b0; b_last = 1'b0;
        idle();
        idle();
        $display("big packet writes=%0d done=%0d", b_wr_cnt, b_done_cnt);
        chk("big_write_cnt", 32'(b_wr_cnt), 32'd1024);
        chk("big_done_cnt", 32'(b_done_cnt), 32'd1);
        chk("big_err", {31'b0, b_err}, 32'h0);
        chk("big_loaded", {28'b0, b_loaded}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
